step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter NOTE_COUNT, default 8, number of pattern steps (2..16).
REQ-002 SHALL have parameter STEP_IDX_WIDTH, default $clog2(NOTE_COUNT), step index width.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pulse_step  input  1  one-cycle step strobe (8th note).
REQ-006 SHALL have port pulse_tick  input  1  one-cycle gate subdivision strobe.
REQ-007 SHALL have port gate_ticks  input  4  note length in pulse_tick units.
REQ-008 SHALL have port busy  input  1  downstream MIDI sender busy flag.
REQ-009 SHALL have port pulse_send  output  1  one-cycle send request to the sender.
REQ-010 SHALL have port msg_off  output  1  1 = note-off message, 0 = note-on.
REQ-011 SHALL have port midi_note  output  7  note number, valid while pulse_send=1.
REQ-012 SHALL have port midi_velocity  output  7  velocity, valid while pulse_send=1.
REQ-013 SHALL have port step_idx  output  STEP_IDX_WIDTH  index of current step.
REQ-014 SHALL have port overrun  output  1  sticky: step strobe dropped.

Function
REQ-015 SHALL run FSM states IDLE, SEND_ON, ACK_ON, DONE_ON, GATE, SEND_OFF, ACK_OFF, DONE_OFF.
REQ-016 IDLE + pulse_step (or pending flag set): latch note/velocity from pattern[step_idx]; go to SEND_ON, or stay IDLE and advance step if velocity==0 (rest).
REQ-017 SEND_*: pulse_send=1 for exactly one cycle, only when busy==0; otherwise hold and retry next cycle.
REQ-018 ACK_*: wait for busy==1; DONE_*: wait for busy==0; DONE_ON exits to GATE, DONE_OFF to IDLE.
REQ-019 GATE: count pulse_tick; after max(gate_ticks,1) ticks go to SEND_OFF; gate_ticks sampled on entry to GATE.
REQ-020 SEND_OFF SHALL present msg_off=1, the same midi_note, velocity 0.
REQ-021 step_idx SHALL advance by 1 on entry to GATE or on a rest, wrapping NOTE_COUNT-1 -> 0.
REQ-022 pulse_step in GATE SHALL terminate the gate immediately (go to SEND_OFF) and set pending.
REQ-023 pulse_step in any SEND/ACK/DONE state SHALL set pending; if pending already set, SHALL set overrun.
REQ-024 pending SHALL clear when IDLE consumes it; pulse_step and pending in same IDLE cycle count once.
REQ-025 Latency: pulse_step in IDLE with busy==0 -> pulse_send exactly 2 cycles later.
REQ-026 midi_note/midi_velocity/msg_off SHALL stay stable from SEND_* through DONE_*.

Reset
REQ-027 rst SHALL force IDLE, step_idx=0, pulse_send=0, msg_off=0, midi_note=0, midi_velocity=0, overrun=0, pending=0, gate counter=0.
REQ-028 rst mid-note SHALL NOT emit a note-off; downstream is responsible for its own reset.

Configuration
REQ-029 Macro SEQ_NOTE_OFF_EN defined: full behaviour REQ-015..REQ-028.
REQ-030 SEQ_NOTE_OFF_EN undefined: DONE_ON returns to IDLE, GATE/SEND_OFF/ACK_OFF/DONE_OFF absent, msg_off tied 0, pulse_step in GATE rule void, gate_ticks and pulse_tick ignored.

Structure
REQ-031 Package seq_pkg SHALL hold FSM state encoding, NOTE_W=7, VEL_W=7, MAX_GATE=15 and the default pattern table.
REQ-032 Sub-module pattern_rom SHALL map step_idx -> {note, velocity} combinationally from seq_pkg table; default pattern 60/100, 64/100, 67/100, rest, 72/80, 67/80, 64/80, rest.

Verification
REQ-033 pulse_step at cycle 10, busy model 1 cycle after trigger for 30 cycles -> pulse_send at cycle 12, note 60, vel 100, msg_off 0.
REQ-034 gate_ticks=3, pulse_tick every 100 cycles -> note-off (note 60, vel 0, msg_off 1) issued after 3rd tick post-DONE_ON.
REQ-035 Eight pulse_steps spaced 1000 cycles -> 6 note-on/off pairs, steps 3 and 7 silent, step_idx wraps to 0.
REQ-036 pulse_step during GATE -> immediate note-off then next note-on without waiting for further pulse_step; overrun stays 0.
REQ-037 Three pulse_steps while busy held high -> overrun=1, only one pending note sent after busy falls.
REQ-038 rst asserted in GATE -> next cycle all outputs 0, step_idx 0, no pulse_send; build without SEQ_NOTE_OFF_EN -> msg_off never 1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer: FSM encoding, field widths
// and the default eight-step pattern.
package seq_pkg;

  localparam int NOTE_W        = 7;
  localparam int VEL_W         = 7;
  localparam int MAX_GATE      = 15;
  localparam int GATE_W        = $clog2(MAX_GATE + 1);
  localparam int PATTERN_LEN   = 8;
  localparam int PATTERN_IDX_W = $clog2(PATTERN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_ON  = 3'd1,
    ST_ACK_ON   = 3'd2,
    ST_DONE_ON  = 3'd3,
    ST_GATE     = 3'd4,
    ST_SEND_OFF = 3'd5,
    ST_ACK_OFF  = 3'd6,
    ST_DONE_OFF = 3'd7
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } step_t;

  // A velocity of zero marks a rest.
  localparam step_t DEFAULT_PATTERN [PATTERN_LEN] = '{
    '{7'd60, 7'd100},
    '{7'd64, 7'd100},
    '{7'd67, 7'd100},
    '{7'd0,  7'd0},
    '{7'd72, 7'd80},
    '{7'd67, 7'd80},
    '{7'd64, 7'd80},
    '{7'd0,  7'd0}
  };

endpackage

// File: rtl/pattern_rom.sv
// Combinational pattern lookup: step index -> {note, velocity}. Patterns longer
// than the table repeat it.
module pattern_rom
  import seq_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0]  step_idx_i,
  output logic [NOTE_W-1:0] note_o,
  output logic [VEL_W-1:0]  velocity_o
);

  logic [PATTERN_IDX_W-1:0] row;
  step_t                    entry;

  assign row        = PATTERN_IDX_W'(step_idx_i);
  assign entry      = DEFAULT_PATTERN[row];
  assign note_o     = entry.note;
  assign velocity_o = entry.vel;

endmodule

// File: rtl/step_scheduler.sv
// Step sequencer scheduler: walks the pattern on each step strobe and hands note
// messages to a busy/ack MIDI sender. Define SEQ_NOTE_OFF_EN for gated note-offs.
module step_scheduler
  import seq_pkg::*;
#(
  parameter int NOTE_COUNT     = 8,
  parameter int STEP_IDX_WIDTH = $clog2(NOTE_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pulse_step,
  input  logic                      pulse_tick,
  input  logic [3:0]                gate_ticks,
  input  logic                      busy,
  output logic                      pulse_send,
  output logic                      msg_off,
  output logic [NOTE_W-1:0]         midi_note,
  output logic [VEL_W-1:0]          midi_velocity,
  output logic [STEP_IDX_WIDTH-1:0] step_idx,
  output logic                      overrun
);

  state_t                    state_q, state_d;
  logic [STEP_IDX_WIDTH-1:0] step_idx_q, step_idx_d, step_next;
  logic                      pending_q, pending_d;
  logic                      overrun_q, overrun_d;
  logic                      pulse_send_q, pulse_send_d;
  logic [NOTE_W-1:0]         note_q, note_d, rom_note;
  logic [VEL_W-1:0]          vel_q, vel_d, rom_vel;
`ifdef SEQ_NOTE_OFF_EN
  logic                      msg_off_q, msg_off_d;
  logic [GATE_W-1:0]         gate_cnt_q, gate_cnt_d;
  logic [GATE_W-1:0]         gate_len_q, gate_len_d;
  logic                      gate_end;
`else
  logic                      unused_inputs;
  assign unused_inputs = ^{pulse_tick, gate_ticks};
`endif

  pattern_rom #(
    .IDX_W(STEP_IDX_WIDTH)
  ) u_pattern_rom (
    .step_idx_i (step_idx_q),
    .note_o     (rom_note),
    .velocity_o (rom_vel)
  );

  assign step_next = (step_idx_q == STEP_IDX_WIDTH'(NOTE_COUNT - 1)) ?
                     '0 : step_idx_q + STEP_IDX_WIDTH'(1);

`ifdef SEQ_NOTE_OFF_EN
  // A new step strobe cuts the gate short; otherwise the gate lasts gate_len ticks.
  assign gate_end = pulse_step ||
                    (pulse_tick && ((gate_cnt_q + GATE_W'(1)) >= gate_len_q));
`endif

  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    pulse_send_d = 1'b0;
    note_d       = note_q;
    vel_d        = vel_q;
`ifdef SEQ_NOTE_OFF_EN
    msg_off_d    = msg_off_q;
    gate_cnt_d   = gate_cnt_q;
    gate_len_d   = gate_len_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pulse_step || pending_q) begin
          pending_d = 1'b0;
          note_d    = rom_note;
          vel_d     = rom_vel;
`ifdef SEQ_NOTE_OFF_EN
          msg_off_d = 1'b0;
`endif
          if (rom_vel == '0) begin
            step_idx_d = step_next;
          end else begin
            state_d = ST_SEND_ON;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_ON: begin
        if (!busy) begin
          pulse_send_d = 1'b1;
          state_d      = ST_ACK_ON;
        end else begin
          state_d = ST_SEND_ON;
        end
      end
      ST_ACK_ON: begin
        state_d = busy ? ST_DONE_ON : ST_ACK_ON;
      end
      ST_DONE_ON: begin
        if (!busy) begin
          step_idx_d = step_next;
`ifdef SEQ_NOTE_OFF_EN
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          gate_len_d = (gate_ticks == 4'd0) ? GATE_W'(1) : GATE_W'(gate_ticks);
`else
          state_d    = ST_IDLE;
`endif
        end else begin
          state_d = ST_DONE_ON;
        end
      end
`ifdef SEQ_NOTE_OFF_EN
      ST_GATE: begin
        if (gate_end) begin
          state_d   = ST_SEND_OFF;
          msg_off_d = 1'b1;
          vel_d     = '0;
        end else if (pulse_tick) begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end else begin
          gate_cnt_d = gate_cnt_q;
        end
      end
      ST_SEND_OFF: begin
        if (!busy) begin
          pulse_send_d = 1'b1;
          state_d      = ST_ACK_OFF;
        end else begin
          state_d = ST_SEND_OFF;
        end
      end
      ST_ACK_OFF: begin
        state_d = busy ? ST_DONE_OFF : ST_ACK_OFF;
      end
      ST_DONE_OFF: begin
        state_d = busy ? ST_DONE_OFF : ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // One strobe can wait while a message is in flight; a second one is lost.
    if (pulse_step && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
      overrun_d = overrun_q | pending_q;
    end else begin
      overrun_d = overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_idx_q   <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      pulse_send_q <= 1'b0;
      note_q       <= '0;
      vel_q        <= '0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      pulse_send_q <= pulse_send_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
    end
  end

`ifdef SEQ_NOTE_OFF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_off_q  <= 1'b0;
      gate_cnt_q <= '0;
      gate_len_q <= '0;
    end else begin
      msg_off_q  <= msg_off_d;
      gate_cnt_q <= gate_cnt_d;
      gate_len_q <= gate_len_d;
    end
  end

  assign msg_off = msg_off_q;
`else
  assign msg_off = 1'b0;
`endif

  assign pulse_send    = pulse_send_q;
  assign midi_note     = note_q;
  assign midi_velocity = vel_q;
  assign step_idx      = step_idx_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler with a simple busy/ack sender model.
// Expected message streams cover both builds (SEQ_NOTE_OFF_EN defined or not).
module tb_step_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_step;
  logic       pulse_tick;
  logic [3:0] gate_ticks;
  logic       busy;
  logic       pulse_send;
  logic       msg_off;
  logic [6:0] midi_note;
  logic [6:0] midi_velocity;
  logic [2:0] step_idx;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  bit busy_model = 1'b1;
  int busy_left  = 0;
  bit send_prev  = 1'b0;
  bit saw_off    = 1'b0;

  int ev_note[$];
  int ev_vel[$];
  int ev_off[$];
  int ev_cyc[$];
  int exp_note[$];
  int exp_vel[$];
  int exp_off[$];

  step_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .pulse_step    (pulse_step),
    .pulse_tick    (pulse_tick),
    .gate_ticks    (gate_ticks),
    .busy          (busy),
    .pulse_send    (pulse_send),
    .msg_off       (msg_off),
    .midi_note     (midi_note),
    .midi_velocity (midi_velocity),
    .step_idx      (step_idx),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock: log sends, run the sender model, generate the tick strobe.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (pulse_send === 1'b1) begin
      ev_note.push_back(int'(midi_note));
      ev_vel.push_back(int'(midi_velocity));
      ev_off.push_back(int'(msg_off));
      ev_cyc.push_back(cycle);
    end
    if (msg_off === 1'b1) saw_off = 1'b1;
    if (busy_model) begin
      if (send_prev) busy_left = 30;
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    send_prev  = (pulse_send === 1'b1);
    pulse_tick = ((cycle % 100) == 50);
  endtask

  task automatic run_to(input int n);
    while (cycle < n) cyc();
  endtask

  task automatic step_at(input int n);
    run_to(n);
    pulse_step = 1'b1;
    cyc();
    pulse_step = 1'b0;
  endtask

  task automatic add_note(input int n, input int v);
    exp_note.push_back(n);
    exp_vel.push_back(v);
    exp_off.push_back(0);
`ifdef SEQ_NOTE_OFF_EN
    exp_note.push_back(n);
    exp_vel.push_back(0);
    exp_off.push_back(1);
`endif
  endtask

  initial begin
    rst        = 1'b1;
    pulse_step = 1'b0;
    pulse_tick = 1'b0;
    gate_ticks = 4'd3;
    busy       = 1'b0;
    repeat (3) cyc();
    check_eq("rst_pulse_send", pulse_send, 0);
    check_eq("rst_msg_off", msg_off, 0);
    check_eq("rst_note", midi_note, 0);
    check_eq("rst_vel", midi_velocity, 0);
    check_eq("rst_step_idx", step_idx, 0);
    check_eq("rst_overrun", overrun, 0);
    rst   = 1'b0;
    cycle = 0;

    // First note and handshake timing.
    step_at(10);
    run_to(30);
    check_eq("hold_note", midi_note, 60);
    check_eq("hold_vel", midi_velocity, 100);
    check_eq("hold_msg_off", msg_off, 0);
    run_to(60);
    check_eq("step_idx_after_first", step_idx, 1);
`ifdef SEQ_NOTE_OFF_EN
    run_to(260);
    check_eq("off_hold_note", midi_note, 60);
    check_eq("off_hold_vel", midi_velocity, 0);
    check_eq("off_hold_msg_off", msg_off, 1);
`endif

    // Walk the rest of the pattern, including both rests and the wrap.
    for (int s = 1; s < 8; s++) step_at(s * 1000 + 10);
    run_to(7500);
    check_eq("step_idx_wrap", step_idx, 0);
    step_at(8010);

    // Step strobe while the previous note is gating (or idle without note-offs).
    step_at(9010);
    step_at(9100);
    run_to(9500);
    check_eq("no_overrun_gate_cut", overrun, 0);

    // Consume the rest at step 3, then three strobes with the sender stalled.
    step_at(10010);
    run_to(10100);
    busy_model = 1'b0;
    busy       = 1'b1;
    step_at(10110);
    step_at(10120);
    step_at(10130);
    run_to(10140);
    check_eq("overrun_set", overrun, 1);
    run_to(10200);
    busy       = 1'b0;
    busy_left  = 0;
    send_prev  = 1'b0;
    busy_model = 1'b1;
    run_to(10900);
    check_eq("overrun_sticky", overrun, 1);

    // Reset while the step-6 note is gating: no note-off may follow.
    step_at(11010);
    run_to(11100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("mid_rst_pulse_send", pulse_send, 0);
    check_eq("mid_rst_msg_off", msg_off, 0);
    check_eq("mid_rst_note", midi_note, 0);
    check_eq("mid_rst_vel", midi_velocity, 0);
    check_eq("mid_rst_step_idx", step_idx, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    run_to(11400);
    check_eq("post_rst_step_idx", step_idx, 0);

    add_note(60, 100); add_note(64, 100); add_note(67, 100);
    add_note(72, 80);  add_note(67, 80);  add_note(64, 80);
    add_note(60, 100); add_note(64, 100); add_note(67, 100);
    add_note(72, 80);  add_note(67, 80);
    exp_note.push_back(64);
    exp_vel.push_back(80);
    exp_off.push_back(0);

    check_eq("event_count", ev_note.size(), exp_note.size());
    for (int i = 0; i < exp_note.size(); i++) begin
      if (i < ev_note.size()) begin
        check_eq($sformatf("ev%0d_note", i), ev_note[i], exp_note[i]);
        check_eq($sformatf("ev%0d_vel", i), ev_vel[i], exp_vel[i]);
        check_eq($sformatf("ev%0d_off", i), ev_off[i], exp_off[i]);
      end
    end

    if (ev_cyc.size() > 0) check_eq("first_send_cycle", ev_cyc[0], 12);
`ifdef SEQ_NOTE_OFF_EN
    if (ev_cyc.size() > 1)  check_eq("first_off_cycle", ev_cyc[1], 252);
    if (ev_cyc.size() > 15) check_eq("gate_cut_off_cycle", ev_cyc[15], 9102);
    if (ev_cyc.size() > 16) check_eq("gate_cut_next_on_cycle", ev_cyc[16], 9136);
    if (ev_cyc.size() > 18) check_eq("stall_release_cycle", ev_cyc[18], 10201);
    check_eq("saw_note_off", saw_off, 1);
`else
    if (ev_cyc.size() > 8) check_eq("idle_step_send_cycle", ev_cyc[8], 9102);
    if (ev_cyc.size() > 9) check_eq("stall_release_cycle", ev_cyc[9], 10201);
    check_eq("msg_off_never", saw_off, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
